// File: rtl/block_dispatcher.sv
// block_dispatcher: splits a kernel launch into blocks and issues each block to the lowest free core.
module block_dispatcher #(
  parameter int NUM_CORES = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             thread_count,
  input  logic [NUM_CORES-1:0]   core_done_flat,
  output logic [NUM_CORES-1:0]   core_start_flat,
  output logic [NUM_CORES*8-1:0] core_block_id_flat,
  output logic [NUM_CORES*8-1:0] core_thread_count_flat,
  output logic                   done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_CORES-1:0] busy_q, busy_d, start_q, start_d, ret, iss;
  logic [8:0] disp_q, disp_d, fin_q, fin_d, total_q, total_d, fin_sum;
  logic [7:0] tc_q, tc_d, lane_tc;
  logic [NUM_CORES*8-1:0] bid_q, bid_d, tcnt_q, tcnt_d;
  logic done_q, done_d;
  logic [9:0] rem;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= '0;
      start_q <= '0;
      disp_q  <= '0;
      fin_q   <= '0;
      total_q <= '0;
      tc_q    <= '0;
      bid_q   <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      disp_q  <= disp_d;
      fin_q   <= fin_d;
      total_q <= total_d;
      tc_q    <= tc_d;
      bid_q   <= bid_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
    end
  // a core's done is stale while its start pulse is visible, so it never retires in that cycle
  always_comb begin
    ret = busy_q & core_done_flat & ~start_q;
    fin_sum = fin_q;
    for (int i = 0; i < NUM_CORES; i++) fin_sum = fin_sum + 9'(ret[i]);
    rem = 10'(tc_q) - 10'(disp_q) * 10'(THREADS_PER_BLOCK);
    lane_tc = rem >= 10'(THREADS_PER_BLOCK) ? 8'(THREADS_PER_BLOCK) : rem[7:0];
    iss = (state_q == RUN && disp_q < total_q) ? ~busy_q & (busy_q + 1'b1) : '0;
    state_d = state_q;
    busy_d = busy_q;
    start_d = '0;
    disp_d = disp_q;
    fin_d = fin_q;
    total_d = total_q;
    tc_d = tc_q;
    bid_d = bid_q;
    tcnt_d = tcnt_q;
    done_d = done_q;
    case (state_q)
      IDLE: if (start) begin
        tc_d = thread_count;
        total_d = 9'((10'(thread_count) + 10'(THREADS_PER_BLOCK - 1)) / 10'(THREADS_PER_BLOCK));
        disp_d = '0;
        fin_d = '0;
        busy_d = '0;
        done_d = thread_count == 8'd0;
        state_d = thread_count == 8'd0 ? DONE : RUN;
      end
      RUN: begin
        busy_d = (busy_q & ~ret) | iss;
        fin_d = fin_sum;
        start_d = iss;
        disp_d = disp_q + 9'(|iss);
        for (int i = 0; i < NUM_CORES; i++)
          if (iss[i]) begin
            bid_d[i*8 +: 8] = disp_q[7:0];
            tcnt_d[i*8 +: 8] = lane_tc;
          end
        if (fin_sum == total_q) begin
          state_d = DONE;
          done_d = 1'b1;
        end
      end
      DONE: state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign core_start_flat = start_q;
  assign core_block_id_flat = bid_q;
  assign core_thread_count_flat = tcnt_q;
  assign done = done_q;
endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: random and directed kernels against a queue-free behavioural dispatcher model.
module tb_block_dispatcher;
  localparam int NC = 2;
  localparam int TPB = 4;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] thread_count = 0;
  logic [NC-1:0] core_done = 0, core_start;
  logic [NC*8-1:0] bid, tcnt;
  logic done;
  int checks = 0, errors = 0;
  int k, start_want, tc_want, rnd_lat;
  int lat [NC];
  int cnt [NC];
  int m_mode, m_tc, m_total, m_next, m_ret;
  logic [NC-1:0] m_busy, m_start;
  logic [NC*8-1:0] m_bid, m_tcnt;
  logic m_done;
  logic [NC-1:0] h_start [0:2099];
  logic [NC*8-1:0] h_bid [0:2099];
  logic [NC*8-1:0] h_tcnt [0:2099];
  logic h_done [0:2099];

  block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .core_done_flat(core_done), .core_start_flat(core_start),
    .core_block_id_flat(bid), .core_thread_count_flat(tcnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at t=%0t k=%0d: got %0h expected %0h", n, $time, k, a, e);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_tc = 0; m_total = 0; m_next = 0; m_ret = 0;
    m_busy = 0; m_start = 0; m_bid = 0; m_tcnt = 0; m_done = 0;
  endtask

  // mode 0 idle, 1 running, 2 finished; inputs are those sampled at the coming edge
  task automatic model_step();
    logic [NC-1:0] r;
    int fr, left;
    r = m_busy & core_done & ~m_start;
    m_start = 0;
    if (m_mode == 0) begin
      if (start) begin
        m_tc = int'(thread_count);
        m_total = (m_tc + TPB - 1) / TPB;
        m_next = 0; m_ret = 0; m_busy = 0;
        m_done = (m_tc == 0);
        m_mode = (m_tc == 0) ? 2 : 1;
      end
    end else if (m_mode == 1) begin
      fr = -1;
      if (m_next < m_total)
        for (int i = 0; i < NC && fr < 0; i++) if (!m_busy[i]) fr = i;
      m_busy = m_busy & ~r;
      m_ret += $countones(r);
      if (fr >= 0) begin
        left = m_tc - TPB * m_next;
        m_start[fr] = 1'b1;
        m_busy[fr] = 1'b1;
        m_bid[fr*8 +: 8] = 8'(m_next);
        m_tcnt[fr*8 +: 8] = 8'(left > TPB ? TPB : left);
        m_next++;
      end
      if (m_ret == m_total) begin m_mode = 2; m_done = 1; end
    end else if (!start) m_mode = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    chk("core_start", int'(core_start), int'(m_start));
    chk("block_id", int'(bid), int'(m_bid));
    chk("thread_cnt", int'(tcnt), int'(m_tcnt));
    chk("done", int'(done), int'(m_done));
    if (k < 2100) begin
      h_start[k] = core_start; h_bid[k] = bid; h_tcnt[k] = tcnt; h_done[k] = done;
    end
    for (int i = 0; i < NC; i++) begin
      if (cnt[i] > 0) begin
        core_done[i] = 1'b0;
        cnt[i]--;
        if (cnt[i] == 0) core_done[i] = 1'b1;
      end
      if (core_start[i]) cnt[i] = rnd_lat ? int'($urandom_range(1, 6)) : lat[i];
    end
    start = start_want[0];
    thread_count = 8'(tc_want);
    model_step();
    k++;
  endtask

  task automatic run_kernel(input int tc, input int hold);
    k = 0; tc_want = tc; start_want = 1;
    repeat (hold) tick();
    start_want = 0;
    while (m_mode != 0 && k < 2000) tick();
    checks++;
    if (k >= 2000) begin
      errors++;
      $display("FAIL timeout kernel tc=%0d: got %0d cycles expected under 2000", tc, k);
    end
  endtask

  task automatic hard_reset();
    reset = 1;
    model_reset();
    core_done = 0; start = 0; start_want = 0;
    for (int i = 0; i < NC; i++) cnt[i] = 0;
  endtask

  initial begin
    int any;
    rnd_lat = 0; start_want = 0; tc_want = 0; k = 0;
    hard_reset();
    repeat (2) @(negedge clk);
    chk("rst_start", int'(core_start), 0);
    chk("rst_bid", int'(bid), 0);
    chk("rst_done", int'(done), 0);
    reset = 0;
    lat[0] = 5; lat[1] = 5;
    run_kernel(8, 1);
    chk("t8_start_k2", int'(h_start[2]), 2'b01);
    chk("t8_start_k3", int'(h_start[3]), 2'b10);
    chk("t8_bid_k3", int'(h_bid[3]), 16'h0100);
    chk("t8_tcnt_k3", int'(h_tcnt[3]), 16'h0404);
    chk("t8_done_k8", int'(h_done[8]), 0);
    chk("t8_done_k9", int'(h_done[9]), 1);
    run_kernel(10, 1);
    any = 0;
    for (int i = 4; i <= 8; i++) any |= int'(h_start[i]);
    chk("t10_quiet", any, 0);
    chk("t10_start_k9", int'(h_start[9]), 2'b01);
    chk("t10_bid_k9", int'(h_bid[9][7:0]), 2);
    chk("t10_tcnt_k9", int'(h_tcnt[9][7:0]), 2);
    run_kernel(0, 1);
    chk("t0_done_k1", int'(h_done[1]), 1);
    chk("t0_start_k1", int'(h_start[1]), 0);
    lat[0] = 6; lat[1] = 5;
    run_kernel(16, 1);
    chk("t16_start_k10", int'(h_start[10]), 2'b01);
    chk("t16_start_k11", int'(h_start[11]), 2'b10);
    chk("t16_bid_k11", int'(h_bid[11]), 16'h0302);
    k = 0; tc_want = 12; start_want = 1;
    tick();
    start_want = 0;
    repeat (3) tick();
    #2 hard_reset();
    #1;
    chk("mid_rst_start", int'(core_start), 0);
    chk("mid_rst_bid", int'(bid), 0);
    chk("mid_rst_tcnt", int'(tcnt), 0);
    chk("mid_rst_done", int'(done), 0);
    @(negedge clk);
    reset = 0;
    lat[0] = 3; lat[1] = 4;
    run_kernel(4, 1);
    chk("post_rst_start", int'(h_start[2]), 2'b01);
    chk("post_rst_bid", int'(h_bid[2]), 0);
    chk("post_rst_tcnt", int'(h_tcnt[2]), 16'h0004);
    rnd_lat = 1;
    for (int n = 0; n < 30; n++) begin
      int tc;
      tc = (n % 5 == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
      if (n == 7) tc = 255;
      run_kernel(tc, int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
